// File: rtl/unidade_controle_temporizada_if.sv
// Control-unit signal bundle: game-flow inputs from the datapath and the decoded control outputs.
// Purely combinational wiring, no latency of its own.
// No backpressure: inputs are level/pulse flags sampled by the control unit every cycle.
interface unidade_controle_temporizada_if;
    logic       iniciar;
    logic       tem_jogada;
    logic       fim_jogo;
    logic       escolhe_macro;

    logic       sinal_macro;
    logic       troca_jogador;
    logic       zeraR_macro;
    logic       zeraR_micro;
    logic       zeraEdge;
    logic       registraR_macro;
    logic       registraR_micro;
    logic       pronto;
    logic       jogar_macro;
    logic       jogar_micro;
    logic       timeout;
    logic [1:0] jogador_atual;
    logic [3:0] db_estado;

    // Datapath / stimulus side
    modport master (
        output iniciar, tem_jogada, fim_jogo, escolhe_macro,
        input  sinal_macro, troca_jogador, zeraR_macro, zeraR_micro, zeraEdge,
               registraR_macro, registraR_micro, pronto, jogar_macro, jogar_micro,
               timeout, jogador_atual, db_estado
    );

    // Control unit side
    modport slave (
        input  iniciar, tem_jogada, fim_jogo, escolhe_macro,
        output sinal_macro, troca_jogador, zeraR_macro, zeraR_micro, zeraEdge,
               registraR_macro, registraR_micro, pronto, jogar_macro, jogar_micro,
               timeout, jogador_atual, db_estado
    );
endinterface

// File: rtl/unidade_controle_temporizada.sv
// Move-sequencing FSM for a macro/micro board game with per-move timeout and player rotation.
// Moore outputs: every control output follows the state register, one edge after the causing input.
// No backpressure: tem_jogada is a one-cycle pulse consumed only while waiting for a move.
module unidade_controle_temporizada #(
    parameter int N_JOGADORES    = 2,
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int TW             = 16,
    parameter int MODO_LIVRE     = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    unidade_controle_temporizada_if.slave  bus
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        JOGA_MACRO     = 4'h2,
        REGISTRA_MACRO = 4'h3,
        JOGA_MICRO     = 4'h4,
        REGISTRA_MICRO = 4'h5,
        TROCA_JOGADOR  = 4'h6,
        DECIDE_MACRO   = 4'h7,
        ESTOURO        = 4'h8,
        FIM            = 4'hF
    } estado_t;

    localparam logic [TW-1:0] LIMITE    = TW'(TIMEOUT_CICLOS);
    // Only meaningful when the timeout is enabled; expiry is gated below otherwise.
    localparam logic [TW-1:0] LIMITE_M1 = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [1:0]    ULTIMO    = 2'(N_JOGADORES - 1);

    estado_t       estado;
    estado_t       proximo;
    logic [TW-1:0] contador;
    logic [1:0]    jogador;
    logic          aguardando;
    logic          expirou;

    // Waiting for a player input in either board; the timeout only runs here.
    assign aguardando = (estado == JOGA_MACRO) || (estado == JOGA_MICRO);

    // A move arriving on the last allowed cycle beats the timeout.
    assign expirou = (TIMEOUT_CICLOS != 0) && aguardando && !bus.tem_jogada
                     && (contador == LIMITE_M1);

    // State register with asynchronous reset back to inicial.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    // Next-state decode.
    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = JOGA_MACRO;
            JOGA_MACRO: begin
                if (bus.tem_jogada) proximo = REGISTRA_MACRO;
                else if (expirou)   proximo = ESTOURO;
                else                proximo = JOGA_MACRO;
            end
            REGISTRA_MACRO: proximo = JOGA_MICRO;
            JOGA_MICRO: begin
                if (bus.tem_jogada) proximo = REGISTRA_MICRO;
                else if (expirou)   proximo = ESTOURO;
                else                proximo = JOGA_MICRO;
            end
            REGISTRA_MICRO: proximo = TROCA_JOGADOR;
            TROCA_JOGADOR:  proximo = bus.fim_jogo ? FIM : DECIDE_MACRO;
            DECIDE_MACRO:   proximo = (bus.escolhe_macro || (MODO_LIVRE != 0)) ? PREPARACAO
                                                                                : JOGA_MICRO;
            ESTOURO:        proximo = PREPARACAO;
            FIM:            proximo = bus.iniciar ? INICIAL : FIM;
            default:        proximo = INICIAL;
        endcase
    end

    // Per-move timeout counter: restarts on each entry to a waiting state, saturates at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador <= '0;
        end else if (((proximo == JOGA_MACRO) || (proximo == JOGA_MICRO)) && (proximo != estado)) begin
            contador <= '0;
        end else if (aguardando && (contador < LIMITE)) begin
            contador <= contador + 1'b1;
        end
    end

    // Player rotation: cleared when a new game starts, advanced when a turn ends or times out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogador <= '0;
        end else if ((estado == INICIAL) && (proximo == PREPARACAO)) begin
            jogador <= '0;
        end else if ((estado == TROCA_JOGADOR) || (estado == ESTOURO)) begin
            jogador <= (jogador == ULTIMO) ? 2'd0 : jogador + 2'd1;
        end
    end

    // Moore output decode from the current state.
    always_comb begin
        bus.sinal_macro     = 1'b0;
        bus.troca_jogador   = 1'b0;
        bus.zeraR_macro     = 1'b0;
        bus.zeraR_micro     = 1'b0;
        bus.zeraEdge        = 1'b0;
        bus.registraR_macro = 1'b0;
        bus.registraR_micro = 1'b0;
        bus.pronto          = 1'b0;
        bus.jogar_macro     = 1'b0;
        bus.jogar_micro     = 1'b0;
        bus.timeout         = 1'b0;
        case (estado)
            INICIAL: begin
                bus.zeraR_macro = 1'b1;
                bus.zeraR_micro = 1'b1;
                bus.zeraEdge    = 1'b1;
            end
            PREPARACAO: begin
                bus.zeraR_macro = 1'b1;
                bus.zeraR_micro = 1'b1;
            end
            JOGA_MACRO: begin
                bus.jogar_macro = 1'b1;
                bus.sinal_macro = 1'b1;
            end
            REGISTRA_MACRO: begin
                bus.registraR_macro = 1'b1;
                bus.sinal_macro     = 1'b1;
            end
            JOGA_MICRO:     bus.jogar_micro     = 1'b1;
            REGISTRA_MICRO: bus.registraR_micro = 1'b1;
            TROCA_JOGADOR:  bus.troca_jogador   = 1'b1;
            DECIDE_MACRO: begin
                bus.zeraR_micro     = 1'b1;
                bus.registraR_macro = 1'b1;
            end
            ESTOURO: begin
                bus.zeraR_micro   = 1'b1;
                bus.troca_jogador = 1'b1;
                bus.timeout       = 1'b1;
            end
            FIM:            bus.pronto = 1'b1;
            default: begin
                bus.sinal_macro = 1'b0;
            end
        endcase
    end

    assign bus.db_estado     = estado;
    assign bus.jogador_atual = jogador;

endmodule

// File: tb/tb_unidade_controle_temporizada.sv
// Bench for the timed control unit: two instances (2 players / 5-cycle timeout, and
// 3 players / timeout disabled / free macro mode), directed per-cycle stimulus with a
// scoreboard queue per instance drained by a negedge monitor.
module tb_unidade_controle_temporizada;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] jog;
    } exp_t;

    logic clock;
    logic reset;

    unidade_controle_temporizada_if ifa ();
    unidade_controle_temporizada_if ifb ();

    unidade_controle_temporizada #(
        .N_JOGADORES(2), .TIMEOUT_CICLOS(5), .TW(16), .MODO_LIVRE(0)
    ) dut_a (
        .clock(clock), .reset(reset), .bus(ifa)
    );

    unidade_controle_temporizada #(
        .N_JOGADORES(3), .TIMEOUT_CICLOS(0), .TW(16), .MODO_LIVRE(1)
    ) dut_b (
        .clock(clock), .reset(reset), .bus(ifb)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs per state, packed as
    // {sinal_macro, troca_jogador, zeraR_macro, zeraR_micro, zeraEdge,
    //  registraR_macro, registraR_micro, pronto, jogar_macro, jogar_micro, timeout}
    function automatic logic [10:0] outs_of(input logic [3:0] st);
        case (st)
            4'h0:    return 11'b00111000000;
            4'h1:    return 11'b00110000000;
            4'h2:    return 11'b10000000100;
            4'h3:    return 11'b10000100000;
            4'h4:    return 11'b00000000010;
            4'h5:    return 11'b00000010000;
            4'h6:    return 11'b01000000000;
            4'h7:    return 11'b00010100000;
            4'h8:    return 11'b01010000001;
            4'hF:    return 11'b00000001000;
            default: return 11'b00000000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: every mid-cycle, compare each instance that has a pending expectation.
    always @(negedge clock) begin
        if (qa.size() != 0) begin
            exp_t e;
            e = qa.pop_front();
            check("A db_estado", 32'(ifa.db_estado), 32'(e.st));
            check("A jogador_atual", 32'(ifa.jogador_atual), 32'(e.jog));
            check("A outputs", 32'({ifa.sinal_macro, ifa.troca_jogador, ifa.zeraR_macro,
                  ifa.zeraR_micro, ifa.zeraEdge, ifa.registraR_macro, ifa.registraR_micro,
                  ifa.pronto, ifa.jogar_macro, ifa.jogar_micro, ifa.timeout}),
                  32'(outs_of(e.st)));
        end
        if (qb.size() != 0) begin
            exp_t e;
            e = qb.pop_front();
            check("B db_estado", 32'(ifb.db_estado), 32'(e.st));
            check("B jogador_atual", 32'(ifb.jogador_atual), 32'(e.jog));
            check("B outputs", 32'({ifb.sinal_macro, ifb.troca_jogador, ifb.zeraR_macro,
                  ifb.zeraR_micro, ifb.zeraEdge, ifb.registraR_macro, ifb.registraR_micro,
                  ifb.pronto, ifb.jogar_macro, ifb.jogar_micro, ifb.timeout}),
                  32'(outs_of(e.st)));
        end
    end

    // One clock cycle of stimulus for instance A (b=0) or B (b=1): drive inputs,
    // record the state/player the instance must show during this cycle.
    task automatic cyc(input bit b, input bit ini, input bit tj, input bit fj, input bit em,
                       input logic [3:0] st, input logic [1:0] jog);
        exp_t e;
        e.st  = st;
        e.jog = jog;
        if (!b) begin
            ifa.iniciar = ini; ifa.tem_jogada = tj; ifa.fim_jogo = fj; ifa.escolhe_macro = em;
            qa.push_back(e);
        end else begin
            ifb.iniciar = ini; ifb.tem_jogada = tj; ifb.fim_jogo = fj; ifb.escolhe_macro = em;
            qb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    // One completed move on instance B, starting in joga_macro, ending in preparacao.
    task automatic move_b(input logic [1:0] jog, input int espera_macro, input int espera_micro);
        logic [1:0] nj;
        nj = (jog == 2'd2) ? 2'd0 : jog + 2'd1;
        for (int i = 0; i < espera_macro; i++) cyc(1, 0, 0, 0, 0, 4'h2, jog);
        cyc(1, 0, 1, 0, 0, 4'h2, jog);
        cyc(1, 0, 0, 0, 0, 4'h3, jog);
        for (int i = 0; i < espera_micro; i++) cyc(1, 0, 0, 0, 0, 4'h4, jog);
        cyc(1, 0, 1, 0, 0, 4'h4, jog);
        cyc(1, 0, 0, 0, 0, 4'h5, jog);
        cyc(1, 0, 0, 0, 0, 4'h6, jog);
        cyc(1, 0, 0, 0, 0, 4'h7, nj);   // escolhe_macro=0, free mode still returns to preparacao
        cyc(1, 0, 0, 0, 0, 4'h1, nj);
    endtask

    initial begin
        reset = 1'b1;
        ifa.iniciar = 0; ifa.tem_jogada = 0; ifa.fim_jogo = 0; ifa.escolhe_macro = 0;
        ifb.iniciar = 0; ifb.tem_jogada = 0; ifb.fim_jogo = 0; ifb.escolhe_macro = 0;
        @(posedge clock);
        #1;

        // Outputs while reset is held, with inputs trying to start.
        cyc(0, 1, 0, 0, 0, 4'h0, 2'd0);
        cyc(1, 1, 0, 0, 0, 4'h0, 2'd0);
        reset = 1'b0;

        // Normal move; tem_jogada ignored in inicial.
        cyc(0, 0, 1, 0, 0, 4'h0, 2'd0);
        cyc(0, 1, 0, 0, 0, 4'h0, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h1, 2'd0);
        cyc(0, 0, 1, 0, 0, 4'h2, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h3, 2'd0);
        cyc(0, 0, 1, 0, 0, 4'h4, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h5, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h6, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h7, 2'd1);

        // Timeout: exactly five idle cycles in joga_micro, one cycle of estouro, player wraps 1->0.
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 4'h4, 2'd1);
        cyc(0, 0, 0, 0, 0, 4'h8, 2'd1);
        cyc(0, 0, 0, 0, 0, 4'h1, 2'd0);

        // Tie: move arrives on the fifth waiting cycle, no estouro.
        cyc(0, 0, 1, 0, 0, 4'h2, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h3, 2'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 4'h4, 2'd0);
        cyc(0, 0, 1, 0, 0, 4'h4, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h5, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h6, 2'd0);
        cyc(0, 0, 0, 0, 1, 4'h7, 2'd1);   // escolhe_macro -> preparacao
        cyc(0, 0, 0, 0, 0, 4'h1, 2'd1);

        // iniciar ignored while waiting; then game over and restart.
        cyc(0, 1, 0, 0, 0, 4'h2, 2'd1);
        cyc(0, 0, 1, 0, 0, 4'h2, 2'd1);
        cyc(0, 0, 0, 0, 0, 4'h3, 2'd1);
        cyc(0, 0, 1, 0, 0, 4'h4, 2'd1);
        cyc(0, 0, 0, 0, 0, 4'h5, 2'd1);
        cyc(0, 0, 0, 1, 0, 4'h6, 2'd1);
        cyc(0, 0, 1, 0, 0, 4'hF, 2'd0);
        cyc(0, 1, 0, 0, 0, 4'hF, 2'd0);
        cyc(0, 1, 0, 0, 0, 4'h0, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h1, 2'd0);

        // Reach joga_micro with player 1, then reset asynchronously with counter at 3.
        cyc(0, 0, 1, 0, 0, 4'h2, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h3, 2'd0);
        cyc(0, 0, 1, 0, 0, 4'h4, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h5, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h6, 2'd0);
        cyc(0, 0, 0, 0, 0, 4'h7, 2'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 4'h4, 2'd1);
        check("A counter before reset", 32'(dut_a.contador), 32'd3);
        #1 reset = 1'b1;
        #1;
        check("A async db_estado", 32'(ifa.db_estado), 32'h0);
        check("A async jogador", 32'(ifa.jogador_atual), 32'd0);
        check("A async counter", 32'(dut_a.contador), 32'd0);
        check("A async zeraEdge", 32'(ifa.zeraEdge), 32'd1);
        check("A async jogar_micro", 32'(ifa.jogar_micro), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Instance B: three players, free macro mode, no timeout despite long waits.
        cyc(1, 1, 0, 0, 0, 4'h0, 2'd0);
        cyc(1, 0, 0, 0, 0, 4'h1, 2'd0);
        move_b(2'd0, 8, 12);
        move_b(2'd1, 0, 0);
        move_b(2'd2, 0, 0);
        move_b(2'd0, 0, 0);
        cyc(1, 0, 0, 0, 0, 4'h2, 2'd1);

        @(negedge clock);
        #1;
        check("scoreboard A drained", 32'(qa.size()), 32'd0);
        check("scoreboard B drained", 32'(qb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
